// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, link defaults and
// the bit-period helper used by both ends of the host link.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned UART_CLK_FREQ = 50_000_000;
  localparam int unsigned UART_BAUD     = 9600;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable
// reset value so an idle-high line does not look like an edge at reset.
module sync_ff2 #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver for the host link. Oversamples the line on the FPGA
// clock with a bit-period counter and presents each byte on a one-entry
// valid/ready buffer, flagging framing errors and dropped bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE = UART_BAUD
) (
  input  logic       clk_FPGA,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic             rx_s;
  logic             rx_prev;
  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, ferr_d, ovr_d;

  sync_ff2 #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk_FPGA),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign rx_busy = (state != IDLE);

  // State, counters, shift register, output buffer and edge-detect history.
  always_ff @(posedge clk_FPGA or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      shift     <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      rx_prev   <= rx_s;
    end
  end

  // Frame sequencing, sample points and buffer/flag updates.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    shift_d = shift;
    data_d  = rx_data;
    valid_d = rx_valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A handshake empties the buffer; a same-cycle load below refills it.
    if (rx_valid && rx_ready) valid_d = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            if (!rx_valid || rx_ready) begin
              data_d  = shift;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = 8;
  // Pin edge to synchronized edge (E), then E+HALF+9*CPB stop sample, +1 registered.
  localparam int unsigned LAT  = 2 + HALF + 9 * CPB + 1;

  localparam int K_ACC  = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk_FPGA = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  int unsigned cyc = 0;
  int unsigned t_last = 0;
  int          n_pass = 0;
  int          n_total = 0;
  ev_t         evq[$];
  ev_t         expq[$];

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk_FPGA (clk_FPGA),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  always @(posedge clk_FPGA) cyc <= cyc + 1;

  // Observed events: handshakes, framing errors and overruns, stamped by cycle.
  always @(negedge clk_FPGA) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) evq.push_back('{cyc, K_ACC, rx_data});
      if (frame_err) evq.push_back('{cyc, K_FERR, 8'h00});
      if (overrun)   evq.push_back('{cyc, K_OVR, 8'h00});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_FPGA);
    #1;
  endtask

  // Drives one 8N1 frame starting now; records the start-edge cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_last = cyc;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(CPB);
    end
    rx = stop;
    step(CPB);
    rx = 1'b1;
  endtask

  task automatic expect_ev(input int unsigned t0, input int kind, input logic [7:0] d);
    expq.push_back('{t0 + LAT, kind, d});
  endtask

  task automatic compare_events(input string name);
    int n;
    chk({name, "_count"}, evq.size(), expq.size());
    n = (evq.size() < expq.size()) ? evq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_kind"}, evq[i].kind, expq[i].kind);
      chk({name, "_data"}, {24'h0, evq[i].data}, {24'h0, expq[i].data});
      chk({name, "_cyc"},  evq[i].cyc, expq[i].cyc);
    end
    evq.delete();
    expq.delete();
  endtask

  initial begin
    vec_t vecs[5];
    int unsigned c;
    logic [7:0] d;
    logic s;

    vecs[0] = '{8'hA5, 1'b1, K_ACC,  8'hA5};
    vecs[1] = '{8'h00, 1'b1, K_ACC,  8'h00};
    vecs[2] = '{8'hFF, 1'b1, K_ACC,  8'hFF};
    vecs[3] = '{8'h6E, 1'b0, K_FERR, 8'h00};
    vecs[4] = '{8'h80, 1'b1, K_ACC,  8'h80};

    // Reset state.
    #2;
    chk("reset_outputs", {23'h0, rx_data, rx_valid, frame_err, overrun, rx_busy}, 32'h0);
    step(3);
    rst_n = 1'b1;
    step(4);
    chk("idle_after_reset", {30'h0, rx_busy, rx_valid}, 32'h0);

    // Table-driven frames with the consumer always ready.
    rx_ready = 1'b1;
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop);
      expect_ev(t_last, vecs[i].exp_kind, vecs[i].exp_data);
      step(4);
      compare_events("table");
    end

    // Two frames back-to-back with the consumer stalled: second one overruns.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    c = t_last;
    send_frame(8'hC3, 1'b1);
    expect_ev(t_last, K_OVR, 8'h00);
    step(2);
    compare_events("overrun");
    @(negedge clk_FPGA);
    chk("overrun_held_valid", {31'h0, rx_valid}, 32'h1);
    chk("overrun_held_data", {24'h0, rx_data}, 32'h3C);
    step(1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    @(negedge clk_FPGA);
    chk("overrun_drained", {31'h0, rx_valid}, 32'h0);
    chk("overrun_handshakes", evq.size(), 1);
    if (evq.size() == 1) chk("overrun_handshake_data", {24'h0, evq[0].data}, 32'h3C);
    evq.delete();
    step(1);

    // Framing error, then the line held low: nothing starts until it rises and falls.
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    expect_ev(t_last, K_FERR, 8'h00);
    step(40);
    @(negedge clk_FPGA);
    chk("break_not_busy", {31'h0, rx_busy}, 32'h0);
    chk("break_no_valid", {31'h0, rx_valid}, 32'h0);
    step(1);
    rx = 1'b1;
    step(20);
    compare_events("ferr");
    send_frame(8'h01, 1'b1);
    expect_ev(t_last, K_ACC, 8'h01);
    step(4);
    compare_events("after_break");

    // Three-cycle glitch: rejected at the start check, E+HALF.
    c = cyc;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    while (cyc < c + 2 + HALF) step(1);
    @(negedge clk_FPGA);
    chk("glitch_busy_at_check", {31'h0, rx_busy}, 32'h1);
    step(1);
    @(negedge clk_FPGA);
    chk("glitch_idle_after", {31'h0, rx_busy}, 32'h0);
    step(30);
    send_frame(8'h01, 1'b1);
    expect_ev(t_last, K_ACC, 8'h01);
    step(4);
    compare_events("glitch");

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(4 * CPB + HALF);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_outputs", {23'h0, rx_data, rx_valid, frame_err, overrun, rx_busy}, 32'h0);
    step(3);
    rst_n = 1'b1;
    step(80);
    chk("midframe_reset_idle", {31'h0, rx_busy}, 32'h0);
    send_frame(8'h81, 1'b1);
    expect_ev(t_last, K_ACC, 8'h81);
    step(4);
    compare_events("after_reset");

    // New byte completes in the same cycle the held byte is consumed.
    rx_ready = 1'b0;
    send_frame(8'h0F, 1'b1);
    step(4);
    evq.delete();
    c = cyc;
    fork
      send_frame(8'h10, 1'b1);
      begin
        while (cyc < c + LAT - 1) step(1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        @(negedge clk_FPGA);
        chk("swap_valid", {31'h0, rx_valid}, 32'h1);
        chk("swap_data", {24'h0, rx_data}, 32'h10);
        chk("swap_no_overrun", {31'h0, overrun}, 32'h0);
      end
    join
    step(4);
    expq.push_back('{c + LAT - 1, K_ACC, 8'h0F});
    compare_events("swap");
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    expq.push_back('{cyc - 1, K_ACC, 8'h10});
    step(1);
    compare_events("swap_drain");

    // Randomized frames against the frame-level reference model.
    rx_ready = 1'b1;
    s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step((s ? 0 : 1) + $urandom_range(0, 12));
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, s);
      if (s) expect_ev(t_last, K_ACC, d);
      else   expect_ev(t_last, K_FERR, 8'h00);
    end
    step(6);
    compare_events("random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
